// File: rtl/avl_resp_pkg.sv
// Shared constants for avl_mem_responder: FSM encoding, output polarity and the
// random-stall LFSR used when AVL_RESP_RAND_STALL_EN is defined.
package avl_resp_pkg;

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam logic ASSERTED   = 1'b1;
  localparam logic DEASSERTED = 1'b0;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avl_rd_pipe.sv
// Fixed-latency read return pipeline: DEPTH stages of {valid, data}, flushed by reset.
module avl_rd_pipe
  import avl_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]      vld_r;
  logic [DATA_WIDTH-1:0] dat_r [DEPTH];

  // Shift {valid,data} one stage per cycle; idle slots carry zero data
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_r <= {DEPTH{DEASSERTED}};
      for (int i = 0; i < DEPTH; i++) dat_r[i] <= {DATA_WIDTH{1'b0}};
    end else begin
      vld_r[0] <= in_valid;
      dat_r[0] <= in_valid ? in_data : {DATA_WIDTH{1'b0}};
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i] <= vld_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_data  = dat_r[DEPTH-1];

endmodule

// File: rtl/avl_mem_responder.sv
// Avalon-MM on-chip memory standing in for an EMIF: calibration delay, periodic
// wait-request stalls, fixed read latency. Define AVL_RESP_RAND_STALL_EN for extra LFSR stalls.
module avl_mem_responder
  import avl_resp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 29,
  parameter int MEM_WORDS   = 4096,
  parameter int INIT_CYCLES = 64,
  parameter int RD_LATENCY  = 3,
  parameter int WAIT_PERIOD = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  avl_write_req,
  input  logic                  avl_read_req,
  input  logic [ADDR_WIDTH-1:0] avl_addr,
  input  logic [DATA_WIDTH-1:0] avl_wdata,
  output logic                  avl_ready,
  output logic [DATA_WIDTH-1:0] avl_rdata,
  output logic                  avl_rdata_valid,
  output logic                  ram_rdy,
  output logic                  addr_err,
  output logic                  proto_err
);

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int INIT_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int PER_W   = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;
  localparam int STALL_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(WAIT_PERIOD - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(WAIT_CYCLES - 1);

  logic [1:0]            state_r;
  logic [INIT_W-1:0]     init_cnt_r;
  logic [PER_W-1:0]      per_cnt_r;
  logic [STALL_W-1:0]    stall_cnt_r;
  logic                  avl_ready_r;
  logic                  ram_rdy_r;
  logic                  addr_err_r;
  logic                  proto_err_r;
  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

  logic [IDX_W-1:0]      idx_s;
  logic                  in_range_s;
  logic                  accept_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  period_hit_s;
  logic                  rand_hit_s;
  logic                  stall_go_s;

`ifdef AVL_RESP_RAND_STALL_EN
  logic [15:0] lfsr_r;

  // LFSR steps only in RUN, so the stall pattern depends only on time since calibration
  always_ff @(posedge clk) begin
    if (!reset) lfsr_r <= LFSR_SEED;
    else if (state_r == RUN) lfsr_r <= lfsr_next(lfsr_r);
  end

  assign rand_hit_s = (state_r == RUN) && (lfsr_r[3:0] == 4'h0);
`else
  assign rand_hit_s = DEASSERTED;
`endif

  // Address decode and command qualification; a read paired with a write is dropped
  always_comb begin
    idx_s        = avl_addr[IDX_W-1:0];
    in_range_s   = (avl_addr[ADDR_WIDTH-1:IDX_W] == {(ADDR_WIDTH-IDX_W){1'b0}});
    accept_s     = reset & avl_ready_r & (avl_write_req | avl_read_req);
    wr_en_s      = accept_s & avl_write_req & in_range_s;
    rd_en_s      = accept_s & avl_read_req & ~avl_write_req;
    rd_data_s    = in_range_s ? mem_r[idx_s] : {DATA_WIDTH{1'b0}};
    period_hit_s = (WAIT_PERIOD != 0) && accept_s && (per_cnt_r == PER_LAST);
    stall_go_s   = period_hit_s | rand_hit_s;
  end

  // Storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[idx_s] <= avl_wdata;
  end

  // Calibration / run / stall sequencing, stall period counter and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= INIT;
      init_cnt_r  <= {INIT_W{1'b0}};
      per_cnt_r   <= {PER_W{1'b0}};
      stall_cnt_r <= {STALL_W{1'b0}};
      avl_ready_r <= DEASSERTED;
      ram_rdy_r   <= DEASSERTED;
      addr_err_r  <= DEASSERTED;
      proto_err_r <= DEASSERTED;
    end else begin
      case (state_r)
        INIT: begin
          if (init_cnt_r == INIT_LAST) begin
            state_r     <= RUN;
            ram_rdy_r   <= ASSERTED;
            avl_ready_r <= ASSERTED;
          end else begin
            init_cnt_r <= init_cnt_r + {{(INIT_W-1){1'b0}}, 1'b1};
          end
        end
        RUN: begin
          if (stall_go_s) begin
            state_r     <= STALL;
            avl_ready_r <= DEASSERTED;
            stall_cnt_r <= {STALL_W{1'b0}};
          end
        end
        STALL: begin
          if (stall_cnt_r == STALL_LAST) begin
            state_r     <= RUN;
            avl_ready_r <= ASSERTED;
          end else begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r     <= INIT;
          avl_ready_r <= DEASSERTED;
          ram_rdy_r   <= DEASSERTED;
        end
      endcase

      if (accept_s && (WAIT_PERIOD != 0)) begin
        per_cnt_r <= period_hit_s ? {PER_W{1'b0}} : per_cnt_r + {{(PER_W-1){1'b0}}, 1'b1};
      end
      if (accept_s && !in_range_s) addr_err_r <= ASSERTED;
      if (accept_s && avl_write_req && avl_read_req) proto_err_r <= ASSERTED;
    end
  end

  avl_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en_s),
    .in_data   (rd_data_s),
    .out_valid (avl_rdata_valid),
    .out_data  (avl_rdata)
  );

  assign avl_ready = avl_ready_r;
  assign ram_rdy   = ram_rdy_r;
  assign addr_err  = addr_err_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Self-checking bench for avl_mem_responder: vector table plus read scoreboard.
// Define AVL_RESP_RAND_STALL_EN to exercise the LFSR stall source with a longer random run.
module tb_avl_mem_responder;

  localparam int DW     = 32;
  localparam int AW     = 29;
  localparam int MW     = 4096;
  localparam int INIT_C = 64;
  localparam int LAT    = 3;
  localparam int WP     = 16;
  localparam int WC     = 2;
`ifdef AVL_RESP_RAND_STALL_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 300;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          avl_ready;
  logic [DW-1:0] avl_rdata;
  logic          avl_rdata_valid;
  logic          ram_rdy;
  logic          addr_err;
  logic          proto_err;

  always #5 clk = ~clk;

  avl_mem_responder dut (
    .clk             (clk),
    .reset           (reset),
    .avl_write_req   (wr),
    .avl_read_req    (rd),
    .avl_addr        (addr),
    .avl_wdata       (wdata),
    .avl_ready       (avl_ready),
    .avl_rdata       (avl_rdata),
    .avl_rdata_valid (avl_rdata_valid),
    .ram_rdy         (ram_rdy),
    .addr_err        (addr_err),
    .proto_err       (proto_err)
  );

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    bit            w;
    bit            r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_rd;
    bit            exp_aerr;
    bit            exp_perr;
  } vec_t;

  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            gap;
  } cmd_t;

  exp_t          sb[$];
  logic [DW-1:0] model [int];
  vec_t          vecs[$];
  cmd_t          cmds [N_RAND];
  bit            kn [64];
  bit            trace[$];
  bit            trace1[$];
  bit            trace2[$];
  bit            rec = 1'b0;
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; outputs are sampled on the falling edge and matched against the scoreboard
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rec) trace.push_back(avl_ready);
    if (avl_rdata_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: avl_rdata_valid=1 rdata=%0h with no read outstanding (cycle %0d)", avl_rdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_cycle", 64'(cyc), 64'(e.due));
        check("rd_data", 64'(avl_rdata), 64'(e.data));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL rd_missing: no avl_rdata_valid, expected data %0h due at cycle %0d", e.data, e.due);
    end
  endtask

  // Present a command, hold it until accepted; while stalled drive a decoy write that must be ignored
  task automatic issue(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_rd, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    while (avl_ready !== 1'b1 && n < 50) begin
      wr = 1'b1; rd = 1'b0; addr = a; wdata = ~d;
      tick();
      n++;
    end
    wr = w; rd = r; addr = a; wdata = d;
    if (avl_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: avl_ready=%b after %0d cycles, required 1", avl_ready, n);
    end else begin
      if (r && !w) sb.push_back('{cyc + LAT, exp_rd});
      if (w && a < MW) model[int'(a)] = d;
      acc_cyc = cyc + 1;
      tick();
    end
    wr = 1'b0;
    rd = 1'b0;
  endtask

  // Synchronous reset for 'cycles' clocks; request lines held for the first reset edge
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    sb.delete();
    tick();
    wr = 1'b0;
    rd = 1'b0;
    repeat (cycles - 1) tick();
    check("rst_ram_rdy", 64'(ram_rdy), 64'd0);
    check("rst_avl_ready", 64'(avl_ready), 64'd0);
    check("rst_rdata_valid", 64'(avl_rdata_valid), 64'd0);
    check("rst_rdata", 64'(avl_rdata), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    reset = 1'b1;
  endtask

  task automatic init_window();
    for (int i = 1; i <= INIT_C; i++) begin
      tick();
      check("init_ram_rdy", 64'(ram_rdy), 64'(i == INIT_C));
      check("init_avl_ready", 64'(avl_ready), 64'(i == INIT_C));
    end
  endtask

  task automatic run_random();
    int n;
    int acc;
    do_reset(2);
    rec = 1'b1;
    n = 0;
    while (ram_rdy !== 1'b1 && n < 200) begin tick(); n++; end
    for (int i = 0; i < N_RAND; i++) begin
      logic [DW-1:0] e;
      e = '0;
      if (!cmds[i].w) e = model[int'(cmds[i].a)];
      issue(cmds[i].w, !cmds[i].w, cmds[i].a, cmds[i].d, e, acc);
      repeat (cmds[i].gap) tick();
    end
    repeat (LAT + 2) tick();
    rec = 1'b0;
  endtask

  initial begin
    int acc [20];
    int acc1;
    int mism;
    int lows;

    vecs.push_back('{1'b1, 1'b0, 29'd5,    32'hDEADBEEF, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd5,    32'h0,        32'hDEADBEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 29'd6,    32'h12345678, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd6,    32'h0,        32'h12345678, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd5,    32'h0,        32'hDEADBEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 29'd4095, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd4095, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 29'd1,    32'h11111111, 32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd4096, 32'h0,        32'h0,        1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 29'd4097, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 29'd1,    32'h0,        32'h11111111, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 29'd7,    32'h00000001, 32'h0,        1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 29'd7,    32'h0,        32'h00000001, 1'b1, 1'b1});

    // Reset values and calibration window
    do_reset(3);
    init_window();

    // 20 back-to-back writes: one stall of WC cycles after the 16th accept
    for (int i = 0; i < 20; i++) issue(1'b1, 1'b0, AW'(100 + i), 32'h1000_0000 + DW'(i), '0, acc[i]);
    for (int i = 1; i < 20; i++) check("stall_gap", 64'(acc[i] - acc[i-1]), 64'((i == WP) ? 1 + WC : 1));
    for (int i = 0; i < 20; i++) issue(1'b0, 1'b1, AW'(100 + i), '0, 32'h1000_0000 + DW'(i), acc1);

    // Vector table
    foreach (vecs[i]) begin
      issue(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].exp_rd, acc1);
      check("vec_addr_err", 64'(addr_err), 64'(vecs[i].exp_aerr));
      check("vec_proto_err", 64'(proto_err), 64'(vecs[i].exp_perr));
    end
    repeat (LAT + 2) tick();

    // Reset with reads in flight: they must vanish; RAM survives
    issue(1'b0, 1'b1, 29'd5, '0, 32'hDEADBEEF, acc1);
    issue(1'b0, 1'b1, 29'd6, '0, 32'h12345678, acc1);
    rd = 1'b1;
    addr = 29'd4095;
    do_reset(1);
    init_window();
    issue(1'b0, 1'b1, 29'd5, '0, 32'hDEADBEEF, acc1);
    issue(1'b0, 1'b1, 29'd4095, '0, 32'hCAFEF00D, acc1);
    issue(1'b0, 1'b1, 29'd107, '0, 32'h1000_0007, acc1);
    repeat (LAT + 2) tick();

    // Random traffic, run twice: identical ready trace, scoreboard-checked reads
    for (int i = 0; i < N_RAND; i++) begin
      int k;
      k = $urandom_range(0, 63);
      cmds[i].a   = AW'(200 + k);
      cmds[i].w   = ($urandom_range(0, 1) == 1) || !kn[k];
      cmds[i].d   = $urandom();
      cmds[i].gap = $urandom_range(0, 2);
      if (cmds[i].w) kn[k] = 1'b1;
    end
    run_random();
    trace1 = trace;
    trace.delete();
    run_random();
    trace2 = trace;
    trace.delete();
    check("trace_len", 64'(trace2.size()), 64'(trace1.size()));
    mism = -1;
    lows = 0;
    for (int i = 0; i < trace1.size() && i < trace2.size(); i++) begin
      if (trace1[i] != trace2[i] && mism < 0) mism = i;
      if (i >= INIT_C && !trace1[i]) lows++;
    end
    check("stall_pattern_first_diff", 64'(mism), 64'(-1));
    check("stalls_seen", 64'(lows > 0), 64'd1);
    check("final_addr_err", 64'(addr_err), 64'd0);
    check("final_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
